// File: rtl/byte_frame_packer_if.sv
// rtl/byte_frame_packer_if.sv - byte input and framed ready/valid output bundle
interface byte_frame_packer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  out_last
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output out_data,
    output out_valid,
    output out_last
  );
endinterface

// File: rtl/byte_frame_packer.sv
// rtl/byte_frame_packer.sv - FIFO-buffered packer emitting header/payload/checksum frames
module byte_frame_packer #(
  parameter int          FRAME_LEN  = 4,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [3:0]  SYNC       = 4'hA
) (
  input  logic                          clk,
  input  logic                          reset,
  byte_frame_packer_if.slave            bus,
  output logic                          overflow,
  output logic [15:0]                   frame_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] DEPTH_L    = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] FRAME_L    = LW'(FRAME_LEN);
  localparam logic [LW-1:0] LAST_IDX   = LW'(FRAME_LEN - 1);
  localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    CHECKSUM
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [7:0]    head;
  logic          push;
  logic          pop;
  logic          handshake;

  logic [LW-1:0] idx;
  logic [7:0]    csum;
  logic [3:0]    seq;
  logic          overflow_q;
  logic [15:0]   frame_count_q;

  // Full is judged on the registered level, so a same-cycle pop never frees a slot.
  assign push      = bus.in_valid && (level < DEPTH_L);
  assign handshake = bus.out_valid && bus.out_ready;
  assign pop       = (state_q == PAYLOAD) && bus.out_ready;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
      if (bus.in_valid && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Level is checked only on leaving IDLE; a whole frame is then already buffered.
  always_comb begin
    state_d       = state_q;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_data  = 8'h00;
    case (state_q)
      IDLE: begin
        if (level >= FRAME_L) begin
          state_d = HEADER;
        end
      end
      HEADER: begin
        bus.out_valid = 1'b1;
        bus.out_data  = {SYNC, seq};
        if (bus.out_ready) begin
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        bus.out_valid = 1'b1;
        bus.out_data  = head;
        if (bus.out_ready && (idx == LAST_IDX)) begin
          state_d = CHECKSUM;
        end
      end
      CHECKSUM: begin
        bus.out_valid = 1'b1;
        bus.out_data  = csum;
        bus.out_last  = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx           <= '0;
      csum          <= 8'h00;
      seq           <= 4'h0;
      frame_count_q <= 16'h0000;
    end else if (handshake) begin
      case (state_q)
        HEADER: begin
          idx  <= '0;
          csum <= 8'h00;
        end
        PAYLOAD: begin
          idx  <= idx + LEVEL_ONE;
          csum <= csum + head;
        end
        CHECKSUM: begin
          seq           <= seq + 4'h1;
          frame_count_q <= frame_count_q + 16'h0001;
        end
        default: begin
          idx <= idx;
        end
      endcase
    end
  end

  assign overflow    = overflow_q;
  assign frame_count = frame_count_q;
  assign fifo_level  = level;

endmodule

// File: tb/tb_byte_frame_packer.sv
// tb/tb_byte_frame_packer.sv - randomized scoreboard bench for byte_frame_packer
module tb_byte_frame_packer;
  localparam int FL    = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        overflow;
  logic [15:0] frame_count;
  logic [4:0]  fifo_level;

  always #5 clk = ~clk;

  byte_frame_packer_if bus();

  byte_frame_packer #(
    .FRAME_LEN  (FL),
    .FIFO_DEPTH (DEPTH),
    .SYNC       (4'hA)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .overflow    (overflow),
    .frame_count (frame_count),
    .fifo_level  (fifo_level)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: accepted bytes are chunked into frames and expanded to the byte stream.
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  logic [7:0] pend[$];
  int         mlevel;
  int         mpos;
  int         mframes;
  logic [3:0] mseq;
  logic       movf;
  int         level_breaks = 0;
  int         stall_breaks = 0;
  logic       prev_stall;
  logic [7:0] prev_data;
  logic       prev_last;
  logic       drain_to;

  task automatic model_reset();
    mlevel = 0; mpos = 0; mframes = 0; mseq = 4'h0; movf = 1'b0;
    pend.delete(); got_q.delete(); exp_q.delete();
    prev_stall = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic rdy);
    logic       acc;
    logic [7:0] sum;
    bus.in_valid = v; bus.in_data = d; bus.out_ready = rdy;
    if (fifo_level !== 5'(mlevel)) level_breaks++;
    if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data ||
                       bus.out_last !== prev_last)) stall_breaks++;
    acc = v && (mlevel < DEPTH);
    if (bus.out_valid && rdy) begin
      got_q.push_back({bus.out_last, bus.out_data});
      if (mpos >= 1 && mpos <= FL) mlevel--;
      if (mpos == FL + 1) begin
        mpos = 0; mframes++;
      end else begin
        mpos++;
      end
    end
    if (v && !acc) movf = 1'b1;
    if (acc) begin
      mlevel++;
      pend.push_back(d);
      if (pend.size() == FL) begin
        exp_q.push_back({1'b0, 4'hA, mseq});
        sum = 8'h00;
        for (int i = 0; i < FL; i++) begin
          exp_q.push_back({1'b0, pend[i]});
          sum = sum + pend[i];
        end
        exp_q.push_back({1'b1, sum});
        mseq = mseq + 4'h1;
        pend.delete();
      end
    end
    prev_stall = bus.out_valid && !rdy;
    prev_data  = bus.out_data;
    prev_last  = bus.out_last;
    @(posedge clk); #1;
  endtask

  // mode 0: ready held high, 1: toggling, 2: random
  task automatic drain(input int mode);
    logic r;
    drain_to = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (mpos == 0 && got_q.size() == exp_q.size()) return;
      r = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(i % 2) : 1'($urandom_range(0, 1));
      step(1'b0, 8'h00, r);
    end
    drain_to = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", bus.out_last); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", bus.out_data); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count got %0d exp 0", frame_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_basic();
    logic [8:0] want [6];
    want = '{9'h0A0, 9'h010, 9'h011, 9'h012, 9'h013, 9'h146};
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 1'b1);
    drain(0);
    checks++; if (drain_to) begin errors++; $display("FAIL basic_timeout got timeout exp done"); end
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL basic_len got %0d exp 6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== want[i]) begin errors++; $display("FAIL basic_byte%0d got %h exp %h", i, got_q[i], want[i]); end
    end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL basic_frame_count got %0d exp 1", frame_count); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL basic_level got %0d exp 0", fifo_level); end
  endtask

  task automatic test_checksum_wrap();
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 8'hFF, 1'($urandom_range(0, 1)));
    drain(2);
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL wrap_len got %0d exp 6", got_q.size()); end
    if (got_q.size() == 6) begin
      checks++; if (got_q[0] !== 9'h0A1) begin errors++; $display("FAIL wrap_header got %h exp 0a1", got_q[0]); end
      checks++; if (got_q[5] !== 9'h1FC) begin errors++; $display("FAIL wrap_checksum got %h exp 1fc", got_q[5]); end
    end
  endtask

  task automatic test_back_to_back();
    int   idle = 0;
    logic seen_last = 1'b0;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 8'h00, 1'b1);
      if (!seen_last) seen_last = (got_q.size() > 0) && got_q[got_q.size()-1][8];
      if (seen_last) begin
        if (bus.out_valid) break;
        idle++;
      end
    end
    drain(0);
    checks++; if (idle != 1) begin errors++; $display("FAIL b2b_idle_cycles got %0d exp 1", idle); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (frame_count !== 16'(mframes)) begin errors++; $display("FAIL b2b_frame_count got %0d exp %0d", frame_count, mframes); end
  endtask

  task automatic test_overflow();
    logic [7:0] first [4];
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      if (i < 4) first[i] = b;
      step(1'b1, b, 1'b0);
    end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA0) begin errors++; $display("FAIL ovf_stall_header got %b/%h exp 1/a0", bus.out_valid, bus.out_data); end
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d exp 16", fifo_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    drain(0);
    checks++; if (got_q.size() != 24) begin errors++; $display("FAIL ovf_len got %0d exp 24", got_q.size()); end
    for (int i = 0; i < 4 && i + 1 < got_q.size(); i++) begin
      checks++; if (got_q[i+1] !== {1'b0, first[i]}) begin errors++; $display("FAIL ovf_payload%0d got %h exp %h", i, got_q[i+1], first[i]); end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    checks++; if (frame_count !== 16'd4) begin errors++; $display("FAIL ovf_frame_count got %0d exp 4", frame_count); end
  endtask

  task automatic test_toggle_ready();
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 48; i++) step(1'($urandom_range(0, 1)), 8'($urandom), 1'(i % 2));
    drain(1);
    checks++; if (drain_to) begin errors++; $display("FAIL toggle_timeout got timeout exp done"); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL toggle_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL toggle_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (stall_breaks != 0) begin errors++; $display("FAIL toggle_stall_stable got %0d breaks exp 0", stall_breaks); end
    checks++; if (overflow !== movf) begin errors++; $display("FAIL toggle_overflow got %b exp %b", overflow, movf); end
  endtask

  task automatic test_reset_mid_frame();
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 50 && mpos != 3; i++) step(1'b0, 8'h00, 1'b1);
    checks++; if (mpos != 3) begin errors++; $display("FAIL midrst_reach_payload got pos %0d exp 3", mpos); end
    do_reset();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL midrst_level got %0d exp 0", fifo_level); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL midrst_frame_count got %0d exp 0", frame_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow got %b exp 0", overflow); end
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b1);
    drain(0);
    checks++; if (got_q.size() != 6 || got_q[0] !== 9'h0A0) begin errors++; $display("FAIL midrst_header got %0d bytes hdr %h exp 6 bytes hdr 0a0", got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h000); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_seq_wrap();
    do_reset();
    for (int f = 0; f < 17; f++) begin
      for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'($urandom_range(0, 1)));
      drain(2);
    end
    checks++; if (got_q.size() != 17 * (FL + 2)) begin errors++; $display("FAIL seqwrap_len got %0d exp %0d", got_q.size(), 17 * (FL + 2)); end
    if (got_q.size() > 16 * (FL + 2)) begin
      checks++; if (got_q[16*(FL+2)] !== 9'h0A0) begin errors++; $display("FAIL seqwrap_header17 got %h exp 0a0", got_q[16*(FL+2)]); end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL seqwrap_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (frame_count !== 16'd17) begin errors++; $display("FAIL seqwrap_frame_count got %0d exp 17", frame_count); end
    checks++; if (level_breaks != 0) begin errors++; $display("FAIL level_tracking got %0d breaks exp 0", level_breaks); end
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_checksum_wrap();
    test_back_to_back();
    test_overflow();
    test_toggle_ready();
    test_reset_mid_frame();
    test_seq_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_frame_packer.md
Name: byte_frame_packer

Overview:
- Downstream consumer of the byte-increment stage (8-bit data, 1-bit valid, no backpressure available upstream).
- Buffers incoming bytes in an internal FIFO and groups them into fixed-length frames.
- Emits each frame on a ready/valid byte stream as: header byte, FRAME_LEN payload bytes, checksum byte.
- Reports overflow and completed-frame count for debug/status.

Parameters:
- FRAME_LEN, 4, payload bytes per frame; legal range 1..FIFO_DEPTH.
- FIFO_DEPTH, 16, input FIFO entries; power of 2, at least 2.
- SYNC, 4'hA, upper nibble of every header byte.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  byte from the upstream stage.
- in_valid  input  1  in_data is valid this cycle; no ready is returned upstream.
- out_data  output  8  framed byte stream.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data when out_valid && out_ready.
- out_last  output  1  marks the checksum (final) byte of a frame.
- overflow  output  1  sticky; an input byte was dropped.
- frame_count  output  16  frames fully transferred; wraps 16'hFFFF->0.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous): FIFO emptied (fifo_level=0); FSM to IDLE; seq=0; payload index=0; checksum accumulator=0; overflow=0; frame_count=0; out_valid=0; out_last=0; out_data=0.
- Reset mid-frame discards the partial frame and all FIFO contents; no completion of the frame is attempted.
- Push rule: byte is written when in_valid=1 and fifo_level<FIFO_DEPTH, both evaluated on the registered level.
- A push while full is dropped and sets overflow=1. overflow stays set until reset.
- A pop in the same cycle does not make room for a push while full.
- Simultaneous push and pop when not full: level is unchanged and both take effect.
- A pushed byte is reflected in fifo_level the next cycle.
- FIFO is first-word-fall-through. Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: out_valid=0. Go to HEADER when fifo_level>=FRAME_LEN. Level is checked once at frame start, so the payload can never underflow.
  - HEADER: out_valid=1, out_data={SYNC,seq[3:0]}. On handshake: go to PAYLOAD, idx=0, csum=0.
  - PAYLOAD: out_valid=1, out_data=FIFO head. On handshake: pop, csum=csum+head (mod 256), idx++. After the handshake with idx==FRAME_LEN-1, go to CHECKSUM.
  - CHECKSUM: out_valid=1, out_data=csum, out_last=1. On handshake: seq++ (4-bit, wraps), frame_count++, then go to IDLE.
- out_last is 0 in every state except CHECKSUM.
- Timing:
  - IDLE->HEADER takes one cycle after the level threshold is met.
  - Back-to-back frames insert exactly one IDLE cycle.
  - Minimum latency: byte pushed at edge N, level visible at N+1, FSM enters HEADER at N+2, header byte presented then.
- Stall: while out_valid=1 and out_ready=0, out_data, out_last and state hold stable. out_valid is never withdrawn before its handshake.
- Input accepts continue during stalls and while frames are being emitted.
- The checksum is the modulo-256 sum of payload bytes only; the header byte is excluded.

Test Plan:
- FRAME_LEN=4, push 8'h10,11,12,13, out_ready=1 -> output A0,10,11,12,13,46; out_last only on 46; frame_count=1; fifo_level returns to 0.
- Push FF,FF,FF,FF -> checksum 8'hFC (wrap). A second frame has header A1.
- out_ready=0 with 17 bytes pushed:
  - HEADER stalls with out_data=A0 held.
  - fifo_level=16; 17th byte dropped; overflow=1.
  - Release out_ready -> first 4 payload bytes are the first 4 pushed; overflow remains 1.
- Toggle out_ready every cycle during a frame -> every byte is transferred exactly once, in order; out_data is stable during each stall.
- Run 17 frames -> 17th header is A0 (seq wrap); frame_count=17.
- Assert reset during PAYLOAD after 2 bytes sent -> next cycle out_valid=0, fifo_level=0, frame_count=0, overflow=0. Next 4 pushed bytes yield header A0.
